// File: rtl/riscv_pkg.sv
// Shared RV32 datapath constants and ALU opcodes for the execute-side blocks.
package riscv_pkg;
  localparam int XLEN_DEF       = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int ALU_OP_W_DEF   = 4;

  typedef enum logic [ALU_OP_W_DEF-1:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  // Compares are computed as a subtraction in the shared adder.
  function automatic logic alu_needs_sub(input logic [ALU_OP_W_DEF-1:0] op);
    return (op == ALU_SUB) || (op == ALU_SLT) || (op == ALU_SLTU);
  endfunction
endpackage

// File: rtl/operand_forward_mux.sv
// Three-way operand source select: EX/MEM, then MEM/WB, then register file. x0 never forwards.
module operand_forward_mux #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] i_rs_addr,
  input  logic [XLEN-1:0]       i_rs_data,
  input  logic [REG_ADDR_W-1:0] i_exmem_rd,
  input  logic                  i_exmem_we,
  input  logic [XLEN-1:0]       i_exmem_result,
  input  logic [REG_ADDR_W-1:0] i_memwb_rd,
  input  logic                  i_memwb_we,
  input  logic [XLEN-1:0]       i_memwb_result,
  output logic [XLEN-1:0]       o_data
);
  logic w_ex_hit;
  logic w_wb_hit;

  assign w_ex_hit = i_exmem_we && (i_exmem_rd != '0) && (i_exmem_rd == i_rs_addr);
  assign w_wb_hit = i_memwb_we && (i_memwb_rd != '0) && (i_memwb_rd == i_rs_addr);

  always_comb begin
    o_data = i_rs_data;
    if (w_ex_hit)      o_data = i_exmem_result;
    else if (w_wb_hit) o_data = i_memwb_result;
  end
endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register feeding the EX adder: forwarding, load-use bubble, stall/flush.
module id_ex_operand_stage
  import riscv_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int ALU_OP_W   = ALU_OP_W_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [XLEN-1:0]       pc_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [XLEN-1:0]       rs1_data_i,
  input  logic [XLEN-1:0]       rs2_data_i,
  input  logic [XLEN-1:0]       imm_i,
  input  logic                  use_imm_i,
  input  logic [ALU_OP_W-1:0]   alu_op_i,
  input  logic                  reg_write_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic [REG_ADDR_W-1:0] exmem_rd_i,
  input  logic                  exmem_reg_write_i,
  input  logic [XLEN-1:0]       exmem_result_i,
  input  logic [REG_ADDR_W-1:0] memwb_rd_i,
  input  logic                  memwb_reg_write_i,
  input  logic [XLEN-1:0]       memwb_result_i,
  output logic                  valid_o,
  output logic [XLEN-1:0]       A_o,
  output logic [XLEN-1:0]       B_o,
  output logic                  Sel_o,
  output logic                  C_o,
  output logic [ALU_OP_W-1:0]   alu_op_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  reg_write_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [XLEN-1:0]       store_data_o,
  output logic [XLEN-1:0]       pc_o,
  output logic                  load_use_stall_o
);
  logic                  r_valid;
  logic [XLEN-1:0]       r_pc;
  logic [REG_ADDR_W-1:0] r_rs1;
  logic [REG_ADDR_W-1:0] r_rs2;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [XLEN-1:0]       r_rs1_data;
  logic [XLEN-1:0]       r_rs2_data;
  logic [XLEN-1:0]       r_imm;
  logic                  r_use_imm;
  logic [ALU_OP_W-1:0]   r_alu_op;
  logic                  r_reg_write;
  logic                  r_mem_read;
  logic                  r_mem_write;

  logic                  w_load_use;
  logic                  w_wb_hit_rs1;
  logic                  w_wb_hit_rs2;
  logic [XLEN-1:0]       w_fwd_rs1;
  logic [XLEN-1:0]       w_fwd_rs2;

  assign w_load_use = r_valid && r_mem_read && (r_rd != '0) && valid_i &&
                      ((r_rd == rs1_addr_i) || (r_rd == rs2_addr_i));

  // While held, pick up a retiring MEM/WB value so it is not lost once it leaves the pipe.
  assign w_wb_hit_rs1 = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == r_rs1);
  assign w_wb_hit_rs2 = memwb_reg_write_i && (memwb_rd_i != '0) && (memwb_rd_i == r_rs2);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid     <= 1'b0;
      r_pc        <= '0;
      r_rs1       <= '0;
      r_rs2       <= '0;
      r_rd        <= '0;
      r_rs1_data  <= '0;
      r_rs2_data  <= '0;
      r_imm       <= '0;
      r_use_imm   <= 1'b0;
      r_alu_op    <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (flush_i || (!stall_i && w_load_use)) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else if (stall_i) begin
      if (w_wb_hit_rs1) r_rs1_data <= memwb_result_i;
      if (w_wb_hit_rs2) r_rs2_data <= memwb_result_i;
    end else begin
      r_valid     <= valid_i;
      r_pc        <= pc_i;
      r_rs1       <= rs1_addr_i;
      r_rs2       <= rs2_addr_i;
      r_rd        <= rd_addr_i;
      r_rs1_data  <= rs1_data_i;
      r_rs2_data  <= rs2_data_i;
      r_imm       <= imm_i;
      r_use_imm   <= use_imm_i;
      r_alu_op    <= alu_op_i;
      r_reg_write <= reg_write_i;
      r_mem_read  <= mem_read_i;
      r_mem_write <= mem_write_i;
    end
  end

  operand_forward_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
    .i_rs_addr(r_rs1), .i_rs_data(r_rs1_data),
    .i_exmem_rd(exmem_rd_i), .i_exmem_we(exmem_reg_write_i), .i_exmem_result(exmem_result_i),
    .i_memwb_rd(memwb_rd_i), .i_memwb_we(memwb_reg_write_i), .i_memwb_result(memwb_result_i),
    .o_data(w_fwd_rs1)
  );

  operand_forward_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
    .i_rs_addr(r_rs2), .i_rs_data(r_rs2_data),
    .i_exmem_rd(exmem_rd_i), .i_exmem_we(exmem_reg_write_i), .i_exmem_result(exmem_result_i),
    .i_memwb_rd(memwb_rd_i), .i_memwb_we(memwb_reg_write_i), .i_memwb_result(memwb_result_i),
    .o_data(w_fwd_rs2)
  );

  assign ready_o          = !stall_i && !w_load_use;
  assign load_use_stall_o = w_load_use;
  assign valid_o          = r_valid;
  assign A_o              = w_fwd_rs1;
  assign B_o              = r_use_imm ? r_imm : w_fwd_rs2;
  assign store_data_o     = w_fwd_rs2;
  assign Sel_o            = alu_needs_sub(r_alu_op);
  assign C_o              = 1'b0;
  assign alu_op_o         = r_alu_op;
  assign rd_addr_o        = r_rd;
  assign pc_o             = r_pc;
  assign reg_write_o      = r_reg_write && r_valid;
  assign mem_read_o       = r_mem_read && r_valid;
  assign mem_write_o      = r_mem_write && r_valid;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Scoreboard bench for id_ex_operand_stage: expected EX-side views queued at drive time.
module tb_id_ex_operand_stage;
  import riscv_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i, ready_o;
  logic [31:0] pc_i;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic [31:0] rs1_data_i, rs2_data_i, imm_i;
  logic        use_imm_i;
  logic [3:0]  alu_op_i;
  logic        reg_write_i, mem_read_i, mem_write_i;
  logic        stall_i, flush_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic        exmem_reg_write_i, memwb_reg_write_i;
  logic [31:0] exmem_result_i, memwb_result_i;
  logic        valid_o, Sel_o, C_o;
  logic [31:0] A_o, B_o, store_data_o, pc_o;
  logic [3:0]  alu_op_o;
  logic [4:0]  rd_addr_o;
  logic        reg_write_o, mem_read_o, mem_write_o, load_use_stall_o;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        vld;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
    logic        sel;
    logic        c;
    logic        rw;
    logic        mr;
    logic        mw;
  } exp_t;

  exp_t q[$];
  exp_t e, o;

  id_ex_operand_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i),
    .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i), .use_imm_i(use_imm_i),
    .alu_op_i(alu_op_i), .reg_write_i(reg_write_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .stall_i(stall_i), .flush_i(flush_i),
    .exmem_rd_i(exmem_rd_i), .exmem_reg_write_i(exmem_reg_write_i), .exmem_result_i(exmem_result_i),
    .memwb_rd_i(memwb_rd_i), .memwb_reg_write_i(memwb_reg_write_i), .memwb_result_i(memwb_result_i),
    .valid_o(valid_o), .A_o(A_o), .B_o(B_o), .Sel_o(Sel_o), .C_o(C_o), .alu_op_o(alu_op_o),
    .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o), .mem_read_o(mem_read_o),
    .mem_write_o(mem_write_o), .store_data_o(store_data_o), .pc_o(pc_o),
    .load_use_stall_o(load_use_stall_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t mk(logic v, logic [31:0] a, logic [31:0] b, logic [31:0] st,
                              logic sel, logic rw, logic mr, logic mw);
    exp_t x;
    x = '{vld: v, a: a, b: b, st: st, sel: sel, c: 1'b0, rw: rw, mr: mr, mw: mw};
    return x;
  endfunction

  function automatic exp_t obs();
    exp_t x;
    x = '{vld: valid_o, a: A_o, b: B_o, st: store_data_o, sel: Sel_o, c: C_o,
          rw: reg_write_o, mr: mem_read_o, mw: mem_write_o};
    return x;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_id(logic v, logic [31:0] pc, logic [4:0] rs1, logic [4:0] rs2, logic [4:0] rd,
                          logic [31:0] d1, logic [31:0] d2, logic [31:0] imm, logic ui,
                          logic [3:0] op, logic rw, logic mr, logic mw);
    valid_i = v; pc_i = pc; rs1_addr_i = rs1; rs2_addr_i = rs2; rd_addr_i = rd;
    rs1_data_i = d1; rs2_data_i = d2; imm_i = imm; use_imm_i = ui; alu_op_i = op;
    reg_write_i = rw; mem_read_i = mr; mem_write_i = mw;
  endtask

  task automatic fwd(logic [4:0] exrd, logic exwe, logic [31:0] exres,
                     logic [4:0] wbrd, logic wbwe, logic [31:0] wbres);
    exmem_rd_i = exrd; exmem_reg_write_i = exwe; exmem_result_i = exres;
    memwb_rd_i = wbrd; memwb_reg_write_i = wbwe; memwb_result_i = wbres;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
    drive_id(1'b0, 0, 0, 0, 0, 0, 0, 0, 1'b0, ALU_ADD, 1'b0, 1'b0, 1'b0);
    fwd(0, 1'b0, 0, 0, 1'b0, 0);
    tick(); tick();
    q.push_back(mk(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    e = q.pop_front(); o = obs(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL reset_outputs got=%h exp=%h", o, e); end
    n_tests++;
    if ({load_use_stall_o, ready_o} !== 2'b01) begin
      n_fail++; $display("FAIL reset_hazard got={lu,rdy}=%b exp=01", {load_use_stall_o, ready_o});
    end
    rst_i = 1'b0;
    tick();
  endtask

  task automatic test_add();
    drive_id(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'h0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0);
    q.push_back(mk(1'b1, 32'd5, 32'd7, 32'd7, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    valid_i = 1'b0;
    e = q.pop_front(); o = obs(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL add got=%h exp=%h", o, e); end
    n_tests++;
    if ({rd_addr_o, alu_op_o, pc_o} !== {5'd3, 4'(ALU_ADD), 32'h100}) begin
      n_fail++; $display("FAIL add_fields got rd=%0d op=%0d pc=%h exp rd=3 op=0 pc=100", rd_addr_o, alu_op_o, pc_o);
    end
  endtask

  task automatic test_forward();
    drive_id(1'b1, 32'h104, 5'd1, 5'd2, 5'd9, 32'h99, 32'h3, 32'h0, 1'b0, ALU_SUB, 1'b1, 1'b0, 1'b0);
    tick();
    valid_i = 1'b0;
    fwd(5'd1, 1'b1, 32'h10, 5'd1, 1'b1, 32'h20);
    q.push_back(mk(1'b1, 32'h10, 32'h3, 32'h3, 1'b1, 1'b1, 1'b0, 1'b0));
    #1; e = q.pop_front(); o = obs(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL fwd_exmem_wins got=%h exp=%h", o, e); end
    fwd(5'd0, 1'b1, 32'h10, 5'd1, 1'b0, 32'h20);
    q.push_back(mk(1'b1, 32'h99, 32'h3, 32'h3, 1'b1, 1'b1, 1'b0, 1'b0));
    #1; e = q.pop_front(); o = obs(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL fwd_x0_guard got=%h exp=%h", o, e); end
    fwd(5'd1, 1'b0, 32'h10, 5'd1, 1'b1, 32'h20);
    q.push_back(mk(1'b1, 32'h20, 32'h3, 32'h3, 1'b1, 1'b1, 1'b0, 1'b0));
    #1; e = q.pop_front(); o = obs(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL fwd_memwb got=%h exp=%h", o, e); end
    fwd(5'd2, 1'b1, 32'h44, 5'd0, 1'b0, 32'h0);
    q.push_back(mk(1'b1, 32'h99, 32'h44, 32'h44, 1'b1, 1'b1, 1'b0, 1'b0));
    #1; e = q.pop_front(); o = obs(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL fwd_rs2 got=%h exp=%h", o, e); end
    fwd(0, 1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic test_load_use();
    drive_id(1'b1, 32'h200, 5'd1, 5'd0, 5'd4, 32'h200, 32'h0, 32'd8, 1'b1, ALU_ADD, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 32'h204, 5'd4, 5'd1, 5'd5, 32'h0, 32'h3, 32'h0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0);
    #1; n_tests++;
    if ({load_use_stall_o, ready_o} !== 2'b10) begin
      n_fail++; $display("FAIL load_use_detect got={lu,rdy}=%b exp=10", {load_use_stall_o, ready_o});
    end
    q.push_back(mk(1'b1, 32'h200, 32'd8, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0));
    e = q.pop_front(); o = obs(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL load_in_ex got=%h exp=%h", o, e); end
    tick();
    q.push_back(mk(1'b0, 32'h0, 32'h3, 32'h3, 1'b0, 1'b0, 1'b0, 1'b0));
    e = q.pop_front(); o = obs(); n_tests++;
    if (o.vld !== e.vld || o.rw !== e.rw || o.mr !== e.mr || load_use_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL bubble got vld=%b rw=%b mr=%b lu=%b exp 0 0 0 0", o.vld, o.rw, o.mr, load_use_stall_o);
    end
    fwd(0, 1'b0, 0, 5'd4, 1'b1, 32'h55);
    q.push_back(mk(1'b1, 32'h55, 32'h3, 32'h3, 1'b0, 1'b1, 1'b0, 1'b0));
    tick();
    valid_i = 1'b0;
    e = q.pop_front(); o = obs(); n_tests++;
    if (o !== e) begin n_fail++; $display("FAIL load_use_dependent got=%h exp=%h", o, e); end
    fwd(0, 1'b0, 0, 0, 1'b0, 0);
  endtask

  task automatic test_stall();
    drive_id(1'b1, 32'h40, 5'd1, 5'd6, 5'd0, 32'h100, 32'h11, 32'd4, 1'b1, ALU_ADD, 1'b0, 1'b0, 1'b1);
    q.push_back(mk(1'b1, 32'h100, 32'd4, 32'hAB, 1'b0, 1'b0, 1'b0, 1'b1));
    tick();
    stall_i = 1'b1;
    fwd(0, 1'b0, 0, 5'd6, 1'b1, 32'hAB);
    drive_id(1'b1, 32'h99, 5'd7, 5'd8, 5'd9, 32'hDEAD, 32'hBEEF, 32'h0, 1'b0, ALU_SUB, 1'b1, 1'b1, 1'b0);
    #1; n_tests++;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_ready got=%b exp=0", ready_o); end
    for (int i = 0; i < 3; i++) tick();
    fwd(0, 1'b0, 0, 0, 1'b0, 0);
    stall_i = 1'b0;
    valid_i = 1'b0;
    #1; e = q.pop_front(); o = obs(); n_tests++;
    if (o !== e || pc_o !== 32'h40) begin
      n_fail++; $display("FAIL stall_refresh got=%h pc=%h exp=%h pc=40", o, pc_o, e);
    end
  endtask

  task automatic test_flush();
    stall_i = 1'b1; flush_i = 1'b1;
    tick();
    stall_i = 1'b0; flush_i = 1'b0;
    n_tests++;
    if ({valid_o, mem_write_o} !== 2'b00) begin
      n_fail++; $display("FAIL flush_over_stall got={v,mw}=%b exp=00", {valid_o, mem_write_o});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [3];
    ops[0] = ALU_ADD; ops[1] = ALU_SLTU; ops[2] = ALU_XOR;
    for (int i = 0; i < 3; i++) begin
      drive_id(1'b1, 32'h300 + 32'(4*i), 5'(10+i), 5'(20+i), 5'(11+i), 32'h1000 + 32'(i),
               32'h2000 + 32'(i), 32'h0, 1'b0, ops[i], 1'b1, 1'b0, 1'b0);
      q.push_back(mk(1'b1, 32'h1000 + 32'(i), 32'h2000 + 32'(i), 32'h2000 + 32'(i),
                     (i == 1), 1'b1, 1'b0, 1'b0));
      tick();
      e = q.pop_front(); o = obs(); n_tests++;
      if (o !== e) begin n_fail++; $display("FAIL back_to_back[%0d] got=%h exp=%h", i, o, e); end
    end
    valid_i = 1'b0;
    tick();
  endtask

  task automatic test_async_reset();
    drive_id(1'b1, 32'h500, 5'd1, 5'd0, 5'd7, 32'h8, 32'h0, 32'd12, 1'b1, ALU_ADD, 1'b1, 1'b1, 1'b0);
    tick();
    drive_id(1'b1, 32'h504, 5'd7, 5'd2, 5'd8, 32'h0, 32'h1, 32'h0, 1'b0, ALU_ADD, 1'b1, 1'b0, 1'b0);
    #1; n_tests++;
    if ({valid_o, load_use_stall_o} !== 2'b11) begin
      n_fail++; $display("FAIL pre_reset_hazard got={v,lu}=%b exp=11", {valid_o, load_use_stall_o});
    end
    #2 rst_i = 1'b1;
    #1;
    q.push_back(mk(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0));
    e = q.pop_front(); o = obs(); n_tests++;
    if (o !== e || load_use_stall_o !== 1'b0) begin
      n_fail++; $display("FAIL async_reset got=%h lu=%b exp=%h lu=0", o, load_use_stall_o, e);
    end
    rst_i = 1'b0;
    valid_i = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_forward();
    test_load_use();
    test_stall();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
